// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with extended head/tail
// pointers, checkpointable head for branch rollback, and a sticky overflow flag.
module free_list #(
    parameter  int PHYS_REGS = 64,
    parameter  int ARCH_REGS = 32,
    localparam int FL_SZ     = PHYS_REGS - ARCH_REGS,
    localparam int PW        = $clog2(PHYS_REGS) + 1,
    localparam int IW        = $clog2(FL_SZ) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          dequeue_en_i,
    output logic [PW-1:0] dequeue_pr_o,
    output logic          empty_o,
    input  logic          enqueue_en_i,
    input  logic [PW-1:0] enqueue_pr_i,
    output logic [IW-1:0] head_ptr_o,
    input  logic          undo_i,
    input  logic [IW-1:0] undo_head_i,
    output logic [IW-1:0] count_o,
    output logic          overflow_o
);

    localparam int AW = IW - 1;

    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] tail_q, tail_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] buf_q [FL_SZ];

    logic [IW-1:0] head_idx, tail_idx, count_c;
    logic          empty_c, full_c, enq_req, enq_ok;

    // Index wraps at FL_SZ-1 and flips the wrap bit, so non-power-of-two sizes also work.
    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        if (p[AW-1:0] == AW'(FL_SZ - 1)) begin
            return {~p[IW-1], {AW{1'b0}}};
        end
        return p + IW'(1);
    endfunction

    assign head_idx = {1'b0, head_q[AW-1:0]};
    assign tail_idx = {1'b0, tail_q[AW-1:0]};

    always_comb begin
        count_c = '0;
        if (tail_q[IW-1] == head_q[IW-1]) begin
            count_c = tail_idx - head_idx;
        end else begin
            count_c = IW'(FL_SZ) - head_idx + tail_idx;
        end
    end

    assign empty_c = (count_c == '0);
    assign full_c  = (count_c == IW'(FL_SZ));

    // Tag 0 is the hard-wired zero register and is never returned to the pool.
    assign enq_req = enqueue_en_i && (enqueue_pr_i != '0);
    assign enq_ok  = enq_req && !full_c;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q | (enq_req && full_c);
        if (undo_i) begin
            head_d = undo_head_i;
        end else if (dequeue_en_i && !empty_c) begin
            head_d = ptr_inc(head_q);
        end
        if (enq_ok) begin
            tail_d = ptr_inc(tail_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= {1'b1, {AW{1'b0}}};
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FL_SZ; i++) begin
                buf_q[i] <= PW'(ARCH_REGS + i);
            end
        end else if (enq_ok) begin
            buf_q[tail_q[AW-1:0]] <= enqueue_pr_i;
        end
    end

    assign dequeue_pr_o = buf_q[head_q[AW-1:0]];
    assign empty_o      = empty_c;
    assign count_o      = count_c;
    assign head_ptr_o   = head_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: stimulus pushes hand-computed post-edge
// expectations; a negedge monitor pops and compares them.
module tb_free_list;

    localparam int PW = 7;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dequeue_en = 1'b0;
    logic [PW-1:0] dequeue_pr;
    logic          empty;
    logic          enqueue_en = 1'b0;
    logic [PW-1:0] enqueue_pr = '0;
    logic [IW-1:0] head_ptr;
    logic          undo = 1'b0;
    logic [IW-1:0] undo_head = '0;
    logic [IW-1:0] count;
    logic          overflow;

    free_list #(.PHYS_REGS(64), .ARCH_REGS(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dequeue_en_i (dequeue_en),
        .dequeue_pr_o (dequeue_pr),
        .empty_o      (empty),
        .enqueue_en_i (enqueue_en),
        .enqueue_pr_i (enqueue_pr),
        .head_ptr_o   (head_ptr),
        .undo_i       (undo),
        .undo_head_i  (undo_head),
        .count_o      (count),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic          chk_pr;
        logic [PW-1:0] pr;
        logic [IW-1:0] cnt;
        logic          emp;
        logic [IW-1:0] hp;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;

    task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s txn %0d: got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %0d: pr=%0d count=%0d empty=%0b head_ptr=%0d overflow=%0b",
                     e.id, dequeue_pr, count, empty, head_ptr, overflow);
            check("count", e.id, 32'(count), 32'(e.cnt));
            check("empty", e.id, 32'(empty), 32'(e.emp));
            check("head_ptr", e.id, 32'(head_ptr), 32'(e.hp));
            check("overflow", e.id, 32'(overflow), 32'(e.ovf));
            if (e.chk_pr) check("dequeue_pr", e.id, 32'(dequeue_pr), 32'(e.pr));
        end
    end

    task automatic push_exp(input logic cpr, input int epr, input int ecnt,
                            input logic eemp, input int ehp, input logic eovf);
        exp_t e;
        e.id     = n_txn;
        e.chk_pr = cpr;
        e.pr     = PW'(epr);
        e.cnt    = IW'(ecnt);
        e.emp    = eemp;
        e.hp     = IW'(ehp);
        e.ovf    = eovf;
        n_txn++;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; expectation describes outputs after this edge.
    task automatic cyc(input logic deq, input logic enq, input int pr, input logic un, input int uh,
                       input logic cpr, input int epr, input int ecnt, input logic eemp,
                       input int ehp, input logic eovf);
        dequeue_en = deq;
        enqueue_en = enq;
        enqueue_pr = PW'(pr);
        undo       = un;
        undo_head  = IW'(uh);
        @(posedge clk);
        push_exp(cpr, epr, ecnt, eemp, ehp, eovf);
        #1;
        dequeue_en = 1'b0;
        enqueue_en = 1'b0;
        enqueue_pr = '0;
        undo       = 1'b0;
        undo_head  = '0;
    endtask

    // Asserts reset between edges (optionally with busy inputs) and checks the reset state.
    task automatic do_reset(input logic busy);
        @(negedge clk);
        #1;
        dequeue_en = busy;
        enqueue_en = busy;
        enqueue_pr = busy ? PW'(9) : '0;
        undo       = busy;
        undo_head  = busy ? IW'(5) : '0;
        rst_n      = 1'b0;
        @(posedge clk);
        push_exp(1'b1, 32, 32, 1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
        dequeue_en = 1'b0;
        enqueue_en = 1'b0;
        enqueue_pr = '0;
        undo       = 1'b0;
        undo_head  = '0;
        rst_n      = 1'b1;
    endtask

    initial begin
        do_reset(1'b0);

        // Drain all 32 free registers in order, then one ignored dequeue at empty.
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 0, 0, 0, (i != 31), 33 + i, 31 - i, (i == 31), i + 1, 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 32, 0);

        // Enqueue+dequeue at empty: no bypass, enqueue lands; then dequeue it.
        cyc(1, 1, 40, 0, 0, 1, 40, 1, 0, 32, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 33, 0);
        // Freeing the zero register is dropped silently.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 33, 0);

        // Checkpoint rollback.
        do_reset(1'b0);
        cyc(1, 0, 0, 0, 0, 1, 33, 31, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 34, 30, 0, 2, 0);
        cyc(1, 0, 0, 0, 0, 1, 35, 29, 0, 3, 0);
        cyc(1, 0, 0, 1, 0, 1, 32, 32, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 33, 31, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 34, 30, 0, 2, 0);
        cyc(0, 1, 5, 1, 1, 1, 33, 32, 0, 1, 0);

        // Enqueue while full: dropped, sticky overflow.
        cyc(0, 1, 50, 0, 0, 1, 33, 32, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 1, 34, 31, 0, 2, 1);
        cyc(0, 0, 0, 0, 0, 1, 34, 31, 0, 2, 1);
        do_reset(1'b0);

        // Wrap test: one dequeue, then 40 same-cycle dequeue/enqueue pairs.
        cyc(1, 0, 0, 0, 0, 1, 33, 31, 0, 1, 0);
        for (int k = 0; k < 40; k++) begin
            cyc(1, 1, 32 + (k % 32), 0, 0, 1, 32 + ((k + 2) % 32), 31, 0, (k + 2) % 64, 0);
        end

        // Reset mid-operation with every request asserted.
        do_reset(1'b1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
